// File: rtl/pulse_pattern_gen.sv
// rtl/pulse_pattern_gen.sv - three-pulse signature envelope generator with repeat count
//
// Emits a gated envelope tx_en made of three pulses of programmable width.
// Each pulse is followed by a fixed low gap. The whole signature repeats
// repeat_num times, and a value of 0 is treated as 1.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous reset, active-high
//   start      in   sequence request, only honoured in IDLE
//   abort      in   synchronous abort, honoured in any non-IDLE state
//   repeat_num in   sequences to send, latched when start is accepted
//   tx_en      out  registered pulse envelope
//   busy       out  high while a sequence is in progress
//   pulse_idx  out  0 = idle, 1/2/3 = pulse (or its trailing gap) in progress
//   rep_left   out  sequences remaining, including the current one
//   done       out  one-cycle strobe on normal completion
//   aborted    out  one-cycle strobe when abort cuts a sequence short
module pulse_pattern_gen #(
  parameter int PULSE_ONE_W   = 500,
  parameter int PULSE_TWO_W   = 750,
  parameter int PULSE_THREE_W = 1000,
  parameter int GAP_W         = 2000,
  parameter int CNT_W         = 16,
  parameter int REP_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [REP_W-1:0] repeat_num,
  output logic             tx_en,
  output logic             busy,
  output logic [1:0]       pulse_idx,
  output logic [REP_W-1:0] rep_left,
  output logic             done,
  output logic             aborted
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Terminal counts: the counter runs 0..W-1, so a phase lasts exactly W cycles.
  localparam logic [CNT_W-1:0] P1_LAST  = CNT_W'(PULSE_ONE_W - 1);
  localparam logic [CNT_W-1:0] P2_LAST  = CNT_W'(PULSE_TWO_W - 1);
  localparam logic [CNT_W-1:0] P3_LAST  = CNT_W'(PULSE_THREE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_W - 1);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               tx_nx, busy_nx, done_nx, aborted_nx;
  logic [1:0]         idx_nx;
  logic [REP_W-1:0]   rep_nx;
  logic [CNT_W-1:0]   pulse_last;

  // Width of the pulse currently being emitted.
  always_comb begin
    pulse_last = P3_LAST;
    case (pulse_idx)
      2'd1:    pulse_last = P1_LAST;
      2'd2:    pulse_last = P2_LAST;
      default: pulse_last = P3_LAST;
    endcase
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    tx_nx      = tx_en;
    busy_nx    = busy;
    idx_nx     = pulse_idx;
    rep_nx     = rep_left;
    done_nx    = 1'b0;
    aborted_nx = 1'b0;

    if (abort && (state != ST_IDLE)) begin
      // Abort wins over any FSM progress, including a same-cycle completion.
      state_nx   = ST_IDLE;
      cnt_nx     = '0;
      tx_nx      = 1'b0;
      busy_nx    = 1'b0;
      idx_nx     = 2'd0;
      rep_nx     = '0;
      aborted_nx = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          // An abort in IDLE has no effect of its own, but it still suppresses a same-cycle start.
          if (start && !abort) begin
            state_nx = ST_PULSE;
            cnt_nx   = '0;
            tx_nx    = 1'b1;
            busy_nx  = 1'b1;
            idx_nx   = 2'd1;
            rep_nx   = (repeat_num == '0) ? REP_W'(1) : repeat_num;
          end
        end

        ST_PULSE: begin
          if (cnt == pulse_last) begin
            state_nx = ST_GAP;
            cnt_nx   = '0;
            tx_nx    = 1'b0;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end

        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt_nx = '0;
            if (pulse_idx != 2'd3) begin
              state_nx = ST_PULSE;
              tx_nx    = 1'b1;
              idx_nx   = pulse_idx + 2'd1;
            end else if (rep_left > REP_W'(1)) begin
              state_nx = ST_PULSE;
              tx_nx    = 1'b1;
              idx_nx   = 2'd1;
              rep_nx   = rep_left - REP_W'(1);
            end else begin
              // The trailing gap is emitted before completion, so the line is idle.
              state_nx = ST_IDLE;
              busy_nx  = 1'b0;
              idx_nx   = 2'd0;
              rep_nx   = '0;
              done_nx  = 1'b1;
            end
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end

        default: begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
          tx_nx    = 1'b0;
          busy_nx  = 1'b0;
          idx_nx   = 2'd0;
          rep_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      tx_en     <= 1'b0;
      busy      <= 1'b0;
      pulse_idx <= 2'd0;
      rep_left  <= '0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      tx_en     <= tx_nx;
      busy      <= busy_nx;
      pulse_idx <= idx_nx;
      rep_left  <= rep_nx;
      done      <= done_nx;
      aborted   <= aborted_nx;
    end
  end

endmodule

// File: tb/tb_pulse_pattern_gen.sv
// tb/tb_pulse_pattern_gen.sv - self-checking bench for pulse_pattern_gen
module tb_pulse_pattern_gen;

  localparam int W1  = 3;
  localparam int W2  = 4;
  localparam int W3  = 5;
  localparam int G   = 2;
  localparam int CW  = 4;
  localparam int RW  = 3;
  localparam int SEQ = W1 + W2 + W3 + 3 * G;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [RW-1:0] repeat_num = '0;
  logic          tx_en, busy, done, aborted;
  logic [1:0]    pulse_idx;
  logic [RW-1:0] rep_left;

  always #5 clk = ~clk;

  pulse_pattern_gen #(
    .PULSE_ONE_W(W1), .PULSE_TWO_W(W2), .PULSE_THREE_W(W3),
    .GAP_W(G), .CNT_W(CW), .REP_W(RW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .repeat_num(repeat_num),
    .tx_en(tx_en), .busy(busy), .pulse_idx(pulse_idx), .rep_left(rep_left),
    .done(done), .aborted(aborted)
  );

  // {tx_en, busy, pulse_idx, rep_left, done, aborted}
  logic [8:0] dut_vec;
  assign dut_vec = {tx_en, busy, pulse_idx, rep_left, done, aborted};

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: position within the transfer counted in cycles since acceptance.
  bit m_active = 1'b0;
  int m_k      = 0;
  int m_r      = 0;
  bit m_done   = 1'b0;
  bit m_ab     = 1'b0;

  function automatic logic [8:0] model_out();
    int s, q;
    logic tx;
    logic [1:0] idx;
    if (!m_active) return {7'b0, m_done, m_ab};
    s = (m_k - 1) % SEQ;
    q = (m_k - 1) / SEQ;
    if (s < W1)                    begin tx = 1'b1; idx = 2'd1; end
    else if (s < W1 + G)           begin tx = 1'b0; idx = 2'd1; end
    else if (s < W1 + G + W2)      begin tx = 1'b1; idx = 2'd2; end
    else if (s < W1 + 2*G + W2)    begin tx = 1'b0; idx = 2'd2; end
    else if (s < W1 + 2*G + W2 + W3) begin tx = 1'b1; idx = 2'd3; end
    else                           begin tx = 1'b0; idx = 2'd3; end
    return {tx, 1'b1, idx, RW'(m_r - q), 1'b0, 1'b0};
  endfunction

  task automatic model_edge();
    m_done = 1'b0;
    m_ab   = 1'b0;
    if (rst) begin
      m_active = 1'b0;
    end else if (abort && m_active) begin
      m_active = 1'b0;
      m_ab     = 1'b1;
    end else if (m_active) begin
      if (m_k == m_r * SEQ) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end else begin
        m_k++;
      end
    end else if (start && !abort) begin
      m_active = 1'b1;
      m_k      = 1;
      m_r      = (repeat_num == 0) ? 1 : int'(repeat_num);
    end
  endtask

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s cycle %0d: got %b want %b", name, cyc, got, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic cycle(input bit vs_model);
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    if (vs_model) check("model", dut_vec, model_out());
  endtask

  // Run n cycles against the model and return how many done strobes were seen.
  task automatic run(input int n, output int dones);
    dones = 0;
    for (int i = 0; i < n; i++) begin
      cycle(1'b1);
      if (done) dones++;
    end
  endtask

  typedef struct {
    bit            r, s, a;
    logic [RW-1:0] rn;
    logic [8:0]    exp;
  } vec_t;

  vec_t tbl[13];
  int   d;

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 3'd0, 9'b0_0_00_000_0_0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 3'd0, 9'b1_1_01_001_0_0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 3'd0, 9'b1_1_01_001_0_0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 3'd0, 9'b1_1_01_001_0_0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 3'd0, 9'b0_1_01_001_0_0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 3'd0, 9'b0_1_01_001_0_0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 3'd0, 9'b1_1_10_001_0_0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 3'd0, 9'b0_0_00_000_0_1};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 3'd0, 9'b0_0_00_000_0_0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 3'd4, 9'b0_0_00_000_0_0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 3'd2, 9'b1_1_01_010_0_0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 3'd5, 9'b1_1_01_010_0_0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 3'd0, 9'b0_0_00_000_0_0};

    for (int i = 0; i < 13; i++) begin
      rst = tbl[i].r; start = tbl[i].s; abort = tbl[i].a; repeat_num = tbl[i].rn;
      cycle(1'b0);
      check($sformatf("tbl%0d", i), dut_vec, tbl[i].exp);
    end
    rst = 1'b0; start = 1'b0; abort = 1'b0;

    // Single sequence, repeat_num = 1.
    repeat_num = 3'd1; start = 1'b1;
    cycle(1'b1);
    start = 1'b0;
    run(SEQ + 3, d);
    check_int("single_done_count", d, 1);

    // repeat_num = 0 behaves as 1.
    repeat_num = 3'd0; start = 1'b1;
    cycle(1'b1);
    start = 1'b0;
    run(SEQ + 3, d);
    check_int("rep0_done_count", d, 1);

    // Maximum repeat count with start held: restart right after done.
    repeat_num = 3'd7; start = 1'b1;
    run(7 * SEQ + SEQ + 5, d);
    check_int("rep7_done_count", d, 1);
    start = 1'b0;
    run(2, d);
    abort = 1'b1;
    cycle(1'b1);
    abort = 1'b0;
    run(3, d);

    // Abort during pulse 2, then restart a few cycles later.
    repeat_num = 3'd2; start = 1'b1;
    cycle(1'b1);
    start = 1'b0;
    run(W1 + G + 1, d);
    abort = 1'b1;
    cycle(1'b1);
    check("abort_strobe", dut_vec, 9'b0_0_00_000_0_1);
    abort = 1'b0;
    run(3, d);
    start = 1'b1;
    cycle(1'b1);
    check("restart_after_abort", dut_vec, 9'b1_1_01_010_0_0);
    start = 1'b0;
    run(2 * SEQ + 3, d);
    check_int("restart_done_count", d, 1);

    // Reset in the middle of a sequence: no strobes.
    repeat_num = 3'd3; start = 1'b1;
    cycle(1'b1);
    start = 1'b0;
    run(SEQ + 4, d);
    rst = 1'b1;
    cycle(1'b1);
    check("mid_reset", dut_vec, 9'b0);
    rst = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      start      = ($urandom % 4) == 0;
      abort      = ($urandom % 150) == 0;
      rst        = ($urandom % 400) == 0;
      repeat_num = RW'($urandom % 8);
      cycle(1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
